// File: rtl/one_wire_pkg.sv
// rtl/one_wire_pkg.sv - shared 1-Wire timing constants, cycle conversion and slave rx state encoding
package one_wire_pkg;

  // Bus timing in microseconds, common to master transmitter and slave receiver.
  localparam int unsigned RSTL_US   = 480;
  localparam int unsigned PDH_US    = 30;
  localparam int unsigned PDL_US    = 120;
  localparam int unsigned SLOT_US   = 61;
  localparam int unsigned W1L_US    = 6;
  localparam int unsigned W0L_US    = 60;
  localparam int unsigned REC_US    = 1;
  localparam int unsigned SAMPLE_US = 30;

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_mhz);
    return us * clk_mhz;
  endfunction

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_DET,
    S_RST_WAIT,
    S_PDH,
    S_PDL,
    S_PD_REL,
    S_BIT_IDLE,
    S_BIT_SAMPLE,
    S_BIT_HOLD
  } ow_state_t;

endpackage

// File: rtl/one_wire_sync.sv
// rtl/one_wire_sync.sv - 2-flop bus synchroniser with fall/rise edge detection
module one_wire_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic prev;

  // Flops reset to the idle-high bus level so no edge is seen when reset lifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;
  assign rise = ~prev & level;

endmodule

// File: rtl/one_wire_slave_rx.sv
// rtl/one_wire_slave_rx.sv - 1-Wire slave: reset detect, presence pulse, LSB-first write-slot byte decode
module one_wire_slave_rx
  import one_wire_pkg::*;
#(
  parameter int unsigned CLK_MHZ      = 100,
  parameter int unsigned T_RST_MIN_US = 400,
  parameter int unsigned T_PDH_US     = 30,
  parameter int unsigned T_PDL_US     = 120,
  parameter int unsigned T_SAMPLE_US  = 30,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        one_wire_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       reset_seen,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] RST_CYC    = CNT_W'(us_to_cyc(T_RST_MIN_US, CLK_MHZ));
  localparam logic [CNT_W-1:0] PDH_CYC    = CNT_W'(us_to_cyc(T_PDH_US, CLK_MHZ));
  localparam logic [CNT_W-1:0] PDL_CYC    = CNT_W'(us_to_cyc(T_PDL_US, CLK_MHZ));
  localparam logic [CNT_W-1:0] SAMPLE_CYC = CNT_W'(us_to_cyc(T_SAMPLE_US, CLK_MHZ));
  // cnt restarts on entry to S_BIT_HOLD, SAMPLE_CYC+1 cycles after the slot fall edge.
  localparam logic [CNT_W-1:0] HOLD_RST_CYC = RST_CYC - SAMPLE_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ow_state_t        state;
  ow_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             drive_low;
  logic             ow_s;
  logic             ow_fall;
  logic             ow_rise;
  logic             sample_now;
  logic             bit_done;
  logic             rst_done;

  assign one_wire_data = drive_low ? 1'b0 : 1'bz;
  assign busy          = (state != S_IDLE);

  one_wire_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (one_wire_data),
    .level (ow_s),
    .fall  (ow_fall),
    .rise  (ow_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sample_now = 1'b0;
    bit_done   = 1'b0;
    rst_done   = 1'b0;
    case (state)
      S_IDLE:       if (ow_fall) state_nxt = S_RST_DET;
      S_RST_DET: begin
        if (ow_rise)             state_nxt = S_IDLE;
        else if (cnt >= RST_CYC) state_nxt = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (ow_rise) begin
          rst_done  = 1'b1;
          state_nxt = S_PDH;
        end
      end
      S_PDH:        if (cnt >= PDH_CYC) state_nxt = S_PDL;
      S_PDL:        if (cnt >= PDL_CYC) state_nxt = S_PD_REL;
      S_PD_REL:     if (ow_s) state_nxt = S_BIT_IDLE;
      S_BIT_IDLE:   if (ow_fall) state_nxt = S_BIT_SAMPLE;
      S_BIT_SAMPLE: begin
        if (cnt == SAMPLE_CYC) begin
          sample_now = 1'b1;
          state_nxt  = S_BIT_HOLD;
        end
      end
      S_BIT_HOLD: begin
        // A write-1 has already risen before the sample point, so the level ends the slot.
        if (ow_s) begin
          bit_done  = 1'b1;
          state_nxt = S_BIT_IDLE;
        end else if (cnt >= HOLD_RST_CYC) begin
          state_nxt = S_RST_WAIT;
        end
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      reset_seen <= 1'b0;
      err        <= 1'b0;
      drive_low  <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      reset_seen <= 1'b0;
      err        <= 1'b0;
      drive_low  <= (state_nxt == S_PDL);

      if (state_nxt != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;

      if (sample_now) shift[bit_idx] <= ow_s;

      if (bit_done) begin
        if (bit_idx == 3'd7) begin
          rx_byte  <= shift;
          rx_valid <= 1'b1;
          bit_idx  <= '0;
        end else begin
          bit_idx <= bit_idx + 3'd1;
        end
      end

      if (rst_done) begin
        reset_seen <= 1'b1;
        err        <= (bit_idx != 3'd0);
        bit_idx    <= '0;
        shift      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_one_wire_slave_rx.sv
// tb/tb_one_wire_slave_rx.sv - scoreboard bench for the 1-Wire slave receiver at 10 MHz
`timescale 1ns/1ps
module tb_one_wire_slave_rx;

  localparam int unsigned PDH_CYC    = 300;   // 30 us at 10 MHz
  localparam int unsigned PDL_CYC    = 1200;  // 120 us
  localparam int unsigned SAMPLE_CYC = 300;   // 30 us
  localparam int unsigned RSTL_CYC   = 4800;  // 480 us master reset
  localparam int unsigned GLITCH_CYC = 1000;  // 100 us
  localparam int unsigned W1L_CYC    = 60;    // 6 us
  localparam int unsigned W0L_CYC    = 600;   // 60 us
  localparam int unsigned SLOT_CYC   = 610;   // 61 us

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       master_low = 1'b0;
  wire        bus;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       reset_seen;
  logic       err;
  logic       busy;

  pullup (bus);
  assign bus = master_low ? 1'b0 : 1'bz;

  one_wire_slave_rx #(
    .CLK_MHZ      (10),
    .T_RST_MIN_US (400),
    .T_PDH_US     (30),
    .T_PDL_US     (120),
    .T_SAMPLE_US  (30),
    .CNT_W        (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .one_wire_data (bus),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .reset_seen    (reset_seen),
    .err           (err),
    .busy          (busy)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic        rs;
    logic        er;
    logic        rv;
    logic [7:0]  b;
    logic [31:0] cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned rs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int unsigned act, input int unsigned lo, input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every strobe must match the next queued expectation, including its cycle.
  always @(negedge clk) begin
    if (rx_valid || reset_seen || err) begin
      if (reset_seen) rs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%b%b%b required=none", reset_seen, err, rx_valid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind", 32'({reset_seen, err, rx_valid}), 32'({mon_e.rs, mon_e.er, mon_e.rv}));
        if (mon_e.rv) chk("rx_byte", 32'(rx_byte), 32'(mon_e.b));
        chk("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_reset(input logic exp_err);
    master_low = 1'b1;
    tick(RSTL_CYC);
    master_low = 1'b0;
    exp_q.push_back('{rs: 1'b1, er: exp_err, rv: 1'b0, b: 8'h00, cyc: cyc + 3});
  endtask

  task automatic wait_bus(input logic lvl, input int unsigned limit, input string name);
    int unsigned n = 0;
    while (bus !== lvl && n < limit) begin
      tick(1);
      n++;
    end
    if (bus !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%b required=%b", name, bus, lvl);
    end
  endtask

  task automatic check_presence();
    int unsigned low_start;
    tick(1);
    chk("busy_after_release", 32'(busy), 32'd1);
    wait_bus(1'b0, 2000, "presence_start");
    low_start = cyc;
    chk_rng("presence_delay", low_start - rs_cyc, PDH_CYC - 1, PDH_CYC + 1);
    chk("busy_in_presence", 32'(busy), 32'd1);
    wait_bus(1'b1, 3000, "presence_end");
    chk_rng("presence_len", cyc - low_start, PDL_CYC - 1, PDL_CYC + 1);
    tick(20);
  endtask

  // Write-1 completes just after the sample point; write-0 completes 3 clk after its rise.
  task automatic send_bit(input logic b, input logic last, input logic [7:0] v);
    int unsigned fall_c;
    fall_c = cyc;
    master_low = 1'b1;
    tick(b ? W1L_CYC : W0L_CYC);
    master_low = 1'b0;
    if (last)
      exp_q.push_back('{rs: 1'b0, er: 1'b0, rv: 1'b1, b: v,
                        cyc: b ? fall_c + SAMPLE_CYC + 5 : cyc + 3});
    tick(SLOT_CYC - (b ? W1L_CYC : W0L_CYC));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], i == 7, v);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    tick(5);
    chk("rst_rx_byte", 32'(rx_byte), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_reset_seen", 32'(reset_seen), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus", 32'(bus), 32'd1);
    rst_n = 1'b1;
    tick(5);

    master_low = 1'b1;
    tick(GLITCH_CYC);
    chk("glitch_busy", 32'(busy), 32'd1);
    master_low = 1'b0;
    tick(10);
    chk("glitch_idle", 32'(busy), 32'd0);
    tick(400);
    chk("glitch_no_drive", 32'(bus), 32'd1);

    send_reset(1'b0);
    check_presence();

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hFF);
    tick(50);
    chk("rx_byte_hold", 32'(rx_byte), 32'hFF);

    send_bit(1'b1, 1'b0, 8'h00);
    send_bit(1'b0, 1'b0, 8'h00);
    send_bit(1'b1, 1'b0, 8'h00);
    send_reset(1'b1);
    check_presence();
    send_byte(8'h3C);
    tick(50);

    send_reset(1'b0);
    wait_bus(1'b0, 2000, "presence2_start");
    tick(500);
    chk("mid_presence_low", 32'(bus), 32'd0);
    rst_n = 1'b0;
    tick(1);
    chk("rstn_bus_released", 32'(bus), 32'd1);
    chk("rstn_busy", 32'(busy), 32'd0);
    chk("rstn_rx_byte", 32'(rx_byte), 32'h00);
    chk("rstn_strobes", 32'({rx_valid, reset_seen, err}), 32'd0);
    rst_n = 1'b1;
    tick(100);
    chk("rstn_stays_idle", 32'(busy), 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
